// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: a busy scoreboard that stalls hazarding issue,
// plus an alternating-priority arbiter that merges ALU and memory writebacks onto one write port.
module regfile_wb_scheduler #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueRd,
    input  logic [ADDR_W-1:0] issueRs1,
    input  logic [ADDR_W-1:0] issueRs2,
    output logic              stall,

    input  logic              aluValid,
    output logic              aluReady,
    input  logic [ADDR_W-1:0] aluRd,
    input  logic [DATA_W-1:0] aluData,

    input  logic              memValid,
    output logic              memReady,
    input  logic [ADDR_W-1:0] memRd,
    input  logic [DATA_W-1:0] memData,

    output logic              regWrite,
    output logic [ADDR_W-1:0] wr,
    output logic [DATA_W-1:0] wdata,

    output logic              idle,
    output logic              errFlag
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic              prio_mem_q;

    logic              issue_hazard;
    logic              issue_accept;
    logic              conflict;
    logic              alu_grant;
    logic              mem_grant;
    logic              xfer;
    logic [ADDR_W-1:0] xfer_rd;
    logic [DATA_W-1:0] xfer_data;
    logic              xfer_wr;
    logic              xfer_orphan;

    // Hazard detection against the scoreboard; register 0 is never marked busy.
    always_comb begin
        issue_hazard = busy_q[issueRs1] | busy_q[issueRs2] | busy_q[issueRd];
        stall        = issueValid & issue_hazard;
        issue_accept = issueValid & ~issue_hazard;
        idle         = ~|busy_q;
    end

    // Single grant per cycle; on conflict the side not served last time wins.
    always_comb begin
        conflict  = aluValid & memValid;
        mem_grant = memValid & (~aluValid | prio_mem_q);
        alu_grant = aluValid & ~mem_grant;
        aluReady  = alu_grant;
        memReady  = mem_grant;
    end

    // Winning writeback payload and its bookkeeping qualifiers.
    always_comb begin
        xfer        = alu_grant | mem_grant;
        xfer_rd     = mem_grant ? memRd   : aluRd;
        xfer_data   = mem_grant ? memData : aluData;
        xfer_wr     = xfer && (xfer_rd != '0);
        xfer_orphan = xfer_wr && !busy_q[xfer_rd];
    end

    // Scoreboard next state: commit clears first, then a same-edge reservation overrides it.
    always_comb begin
        busy_d = busy_q;
        if (regWrite) begin
            busy_d[wr] = 1'b0;
        end
        if (issue_accept && (issueRd != '0)) begin
            busy_d[issueRd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            prio_mem_q <= 1'b1;
            regWrite   <= 1'b0;
            wr         <= '0;
            wdata      <= '0;
            errFlag    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            regWrite <= xfer_wr;
            if (conflict) begin
                prio_mem_q <= ~prio_mem_q;
            end
            if (xfer_wr) begin
                wr    <= xfer_rd;
                wdata <= xfer_data;
            end
            if (xfer_orphan) begin
                errFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: hazard stall, arbitration order, rd=0 drop,
// orphan-write error, set-beats-clear and asynchronous reset.
module tb_regfile_wb_scheduler;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;

    logic              clock;
    logic              reset_n;
    logic              issueValid;
    logic [ADDR_W-1:0] issueRd;
    logic [ADDR_W-1:0] issueRs1;
    logic [ADDR_W-1:0] issueRs2;
    logic              stall;
    logic              aluValid;
    logic              aluReady;
    logic [ADDR_W-1:0] aluRd;
    logic [DATA_W-1:0] aluData;
    logic              memValid;
    logic              memReady;
    logic [ADDR_W-1:0] memRd;
    logic [DATA_W-1:0] memData;
    logic              regWrite;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wdata;
    logic              idle;
    logic              errFlag;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .issueValid(issueValid), .issueRd(issueRd), .issueRs1(issueRs1), .issueRs2(issueRs2),
        .stall(stall),
        .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memRd(memRd), .memData(memData),
        .regWrite(regWrite), .wr(wr), .wdata(wdata),
        .idle(idle), .errFlag(errFlag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                         input logic [ADDR_W-1:0] rs2);
        issueValid = 1'b1;
        issueRd    = rd;
        issueRs1   = rs1;
        issueRs2   = rs2;
    endtask

    initial begin
        reset_n = 1'b0; issueValid = 1'b0; issueRd = '0; issueRs1 = '0; issueRs2 = '0;
        aluValid = 1'b0; aluRd = '0; aluData = '0;
        memValid = 1'b0; memRd = '0; memData = '0;

        #12;
        check("rst_regWrite", 64'(regWrite), 64'd0);
        check("rst_wr",       64'(wr),       64'd0);
        check("rst_wdata",    wdata,         64'd0);
        check("rst_errFlag",  64'(errFlag),  64'd0);
        check("rst_idle",     64'(idle),     64'd1);
        reset_n = 1'b1;
        tick();

        // Reserve r5, stall a reader, retire via ALU.
        issue(5'd5, 5'd1, 5'd2);
        #1 check("iss5_stall", 64'(stall), 64'd0);
        tick();
        issueValid = 1'b0;
        #1 check("busy5_idle", 64'(idle), 64'd0);
        issue(5'd6, 5'd5, 5'd0);
        aluValid = 1'b1; aluRd = 5'd5; aluData = 64'hAA;
        #1 check("raw5_stall", 64'(stall), 64'd1);
        check("alu_only_ready", 64'({aluReady, memReady}), 64'b10);
        tick();
        aluValid = 1'b0;
        check("wb5_regWrite", 64'(regWrite), 64'd1);
        check("wb5_wr",       64'(wr),       64'd5);
        check("wb5_wdata",    wdata,         64'hAA);
        check("wb5_stall",    64'(stall),    64'd1);
        tick();
        check("post_wb_regWrite", 64'(regWrite), 64'd0);
        check("hold_wr",          64'(wr),       64'd5);
        check("hold_wdata",       wdata,         64'hAA);
        check("raw5_released",    64'(stall),    64'd0);
        tick();
        issueValid = 1'b0;
        aluValid = 1'b1; aluRd = 5'd6; aluData = 64'h66;
        tick();
        aluValid = 1'b0;
        check("wb6_wr", 64'(wr), 64'd6);
        tick();
        check("idle_after_wb6", 64'(idle), 64'd1);
        check("no_err_yet",     64'(errFlag), 64'd0);

        // Held conflict alternates M, A, M, A.
        aluValid = 1'b1; aluRd = '0; aluData = 64'h1;
        memValid = 1'b1; memRd = '0; memData = 64'h2;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("conflict_grant%0d", k), 64'({aluReady, memReady}),
                     (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
        end
        aluValid = 1'b0; memValid = 1'b0;
        #1 check("no_valid_no_ready", 64'({aluReady, memReady}), 64'b00);

        // rd=0 writeback is consumed silently.
        issue(5'd3, 5'd0, 5'd0);
        tick();
        issueValid = 1'b0;
        memValid = 1'b1; memRd = '0; memData = 64'h55;
        #1 check("mem_rd0_ready", 64'({aluReady, memReady}), 64'b01);
        tick();
        memValid = 1'b0;
        check("rd0_regWrite", 64'(regWrite), 64'd0);
        check("rd0_wr_hold",  64'(wr),       64'd6);
        check("rd0_idle",     64'(idle),     64'd0);
        check("rd0_errFlag",  64'(errFlag),  64'd0);
        memValid = 1'b1; memRd = 5'd3; memData = 64'h33;
        tick();
        memValid = 1'b0;
        check("wb3_wdata", wdata, 64'h33);
        tick();
        check("idle_after_wb3", 64'(idle), 64'd1);

        // Orphan write to r4 sets errFlag; same-edge reissue of r4 keeps it busy.
        aluValid = 1'b1; aluRd = 5'd4; aluData = 64'h99;
        tick();
        aluValid = 1'b0;
        check("orphan_regWrite", 64'(regWrite), 64'd1);
        check("orphan_wr",       64'(wr),       64'd4);
        check("orphan_errFlag",  64'(errFlag),  64'd1);
        issue(5'd4, 5'd0, 5'd0);
        #1 check("set_vs_clr_stall", 64'(stall), 64'd0);
        tick();
        issueValid = 1'b0;
        #1 check("set_wins_idle", 64'(idle), 64'd0);
        issue(5'd8, 5'd4, 5'd0);
        #1 check("set_wins_stall", 64'(stall), 64'd1);
        issueValid = 1'b0;
        tick(); tick();
        check("err_sticky", 64'(errFlag), 64'd1);

        // Asynchronous reset mid-cycle with reservations and a pending write.
        issue(5'd3, 5'd0, 5'd0);
        tick();
        issue(5'd7, 5'd0, 5'd0);
        tick();
        issueValid = 1'b0;
        aluValid = 1'b1; aluRd = 5'd3; aluData = 64'h77;
        tick();
        aluValid = 1'b0;
        check("pre_rst_regWrite", 64'(regWrite), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_regWrite", 64'(regWrite), 64'd0);
        check("arst_wr",       64'(wr),       64'd0);
        check("arst_wdata",    wdata,         64'd0);
        check("arst_errFlag",  64'(errFlag),  64'd0);
        check("arst_idle",     64'(idle),     64'd1);
        issue(5'd1, 5'd7, 5'd3);
        #1 check("arst_stall", 64'(stall), 64'd0);
        issueValid = 1'b0;
        tick();
        reset_n = 1'b1;
        aluValid = 1'b1; memValid = 1'b1;
        #1 check("arst_prio_mem", 64'({aluReady, memReady}), 64'b01);
        aluValid = 1'b0; memValid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameter DATA_W, default 64, shall set the writeback data width.
REQ-002 Parameter ADDR_W, default 5, shall set the register index width; the register count is 2**ADDR_W (32).
REQ-003 Port clock, input, 1 bit, shall be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit, shall be the reset: asynchronous, active-low.
REQ-005 Port issueValid, input, 1 bit, shall flag an instruction requesting issue this cycle.
REQ-006 Port issueRd, input, ADDR_W bits, shall carry the destination register of the issuing instruction.
REQ-007 Ports issueRs1 and issueRs2, input, ADDR_W bits each, shall carry the source registers of the issuing instruction.
REQ-008 Port stall, output, 1 bit, shall be combinational and shall block issue.
REQ-009 Ports aluValid (input, 1), aluReady (output, 1), aluRd (input, ADDR_W) and aluData (input, DATA_W) shall form writeback requester A.
REQ-010 Ports memValid (input, 1), memReady (output, 1), memRd (input, ADDR_W) and memData (input, DATA_W) shall form writeback requester M.
REQ-011 Ports regWrite (output, 1), wr (output, ADDR_W) and wdata (output, DATA_W) shall be registered outputs driving the register file write port.
REQ-012 Port idle, output, 1 bit, shall be high when no register is reserved.
REQ-013 Port errFlag, output, 1 bit, shall be a sticky writeback-protocol error flag.

Function
REQ-014 The block shall hold a scoreboard busy[2**ADDR_W-1:0]; busy[0] shall read as 0 at all times.
REQ-015 stall shall equal issueValid AND (busy[issueRs1] OR busy[issueRs2] OR busy[issueRd]).
REQ-016 Issue shall be accepted when issueValid=1 and stall=0; if issueRd!=0, busy[issueRd] shall be set on that edge.
REQ-017 A requester shall transfer on an edge where its valid=1 and its ready=1.
REQ-018 Only one requester shall be granted per cycle; aluReady and memReady shall never both be 1.
REQ-019 With exactly one valid, that requester's ready shall be 1 (combinational).
REQ-020 With both valid, the requester not granted in the most recent conflict shall win; the priority bit shall toggle only on conflict-cycle transfers.
REQ-021 Ready shall be 0 whenever the matching valid is 0.
REQ-022 On a transfer with rd!=0, the next cycle shall present regWrite=1, wr=rd and wdata=data.
REQ-023 On a transfer with rd=0, the data shall be consumed and regWrite shall be 0 the next cycle.
REQ-024 On a cycle following no transfer, regWrite shall be 0 and wr/wdata shall hold their last values.
REQ-025 On each edge where regWrite=1, busy[wr] shall be cleared, so the first stall-free reader issues one cycle after the write commits.
REQ-026 If a set (REQ-016) and a clear (REQ-025) target the same register on the same edge, the set shall win.
REQ-027 A transfer with rd!=0 and busy[rd]=0 shall still be written, and shall set errFlag=1 from the next edge until reset.
REQ-028 idle shall be the combinational NOR of busy.
REQ-029 Writeback latency shall be exactly one cycle from transfer to regWrite; stall shall add zero cycles of latency.

Reset
REQ-030 While reset_n=0: busy shall be all zero, regWrite=0, wr=0, wdata=0, errFlag=0, and the priority bit shall favour requester M.
REQ-031 Reset asserted mid-operation shall discard all reservations and any pending write immediately, without waiting for clock.

Verification
REQ-032 Issue rd=5 -> busy[5]=1 and idle=0; next issue with rs1=5 -> stall=1; aluValid rd=5 data=0xAA -> regWrite=1, wr=5, wdata=0xAA one cycle later; stall drops the following cycle.
REQ-033 aluValid and memValid both held valid for 4 cycles -> grants are M, A, M, A; aluReady and memReady are never high together.
REQ-034 memValid with rd=0 -> memReady=1; the next cycle shows regWrite=0; busy, idle and errFlag are unchanged.
REQ-035 aluValid rd=9 with busy[9]=0 -> write occurs and errFlag=1 persists until reset_n=0.
REQ-036 Issue rd=3 and rd=7, then pull reset_n low mid-cycle -> busy, regWrite and errFlag clear immediately and idle=1.
REQ-037 Issue rd=4 on the edge regWrite clears wr=4 -> busy[4] remains 1.
